// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg
//   Shared definitions for the FP operation sequencer:
//   - FOP_* op-class codes presented by decode on req_op
//   - ALU_CTRL_* codes driven to the FP ALU (NOP leaves FpCond untouched)
//   - sequencer state encoding
//   - helpers: op -> ALU control, op -> hold latency, legality, compare class
package fp_seq_pkg;

    localparam logic [2:0] FOP_ADD = 3'd0;
    localparam logic [2:0] FOP_SUB = 3'd1;
    localparam logic [2:0] FOP_MUL = 3'd2;
    localparam logic [2:0] FOP_DIV = 3'd3;
    localparam logic [2:0] FOP_CEQ = 3'd4;
    localparam logic [2:0] FOP_CLT = 3'd5;
    localparam logic [2:0] FOP_CLE = 3'd6;

    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_MUL = 4'b0011;
    localparam logic [3:0] ALU_CTRL_DIV = 4'b0100;
    localparam logic [3:0] ALU_CTRL_CEQ = 4'b1000;
    localparam logic [3:0] ALU_CTRL_CLT = 4'b1001;
    localparam logic [3:0] ALU_CTRL_CLE = 4'b1010;
    localparam logic [3:0] ALU_CTRL_NOP = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } seq_state_t;

    // ALU control code for each op class; undefined ops map to NOP.
    function automatic logic [3:0] ctrl_of(input logic [2:0] op);
        logic [3:0] c;
        case (op)
            FOP_ADD: c = ALU_CTRL_ADD;
            FOP_SUB: c = ALU_CTRL_SUB;
            FOP_MUL: c = ALU_CTRL_MUL;
            FOP_DIV: c = ALU_CTRL_DIV;
            FOP_CEQ: c = ALU_CTRL_CEQ;
            FOP_CLT: c = ALU_CTRL_CLT;
            FOP_CLE: c = ALU_CTRL_CLE;
            default: c = ALU_CTRL_NOP;
        endcase
        return c;
    endfunction

    // Number of cycles the operands must be held for an op class.
    function automatic int unsigned lat_of(input logic [2:0] op,
                                           input int unsigned l_add,
                                           input int unsigned l_mul,
                                           input int unsigned l_div,
                                           input int unsigned l_cmp);
        int unsigned l;
        case (op)
            FOP_ADD, FOP_SUB:          l = l_add;
            FOP_MUL:                   l = l_mul;
            FOP_DIV:                   l = l_div;
            FOP_CEQ, FOP_CLT, FOP_CLE: l = l_cmp;
            default:                   l = 0;
        endcase
        return l;
    endfunction

    function automatic logic is_cmp_op(input logic [2:0] op);
        return (op == FOP_CEQ) || (op == FOP_CLT) || (op == FOP_CLE);
    endfunction

    // The ALU only supports double precision for add/sub.
    function automatic logic is_legal(input logic [2:0] op, input logic dbl);
        logic defined;
        logic addsub;
        defined = (op <= FOP_CLE);
        addsub  = (op == FOP_ADD) || (op == FOP_SUB);
        return defined && (!dbl || addsub);
    endfunction

endpackage

// File: rtl/fp_op_sequencer_if.sv
// fp_op_sequencer_if
//   Bundles the decode request, the ALU operand/control/result bus, the
//   writeback response and the core stall line of the FP op sequencer.
//   slave  : the sequencer
//   master : its environment (decode, FP ALU, writeback, core)
interface fp_op_sequencer_if;
    // decode request
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_dbl;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic        flush;
    // FP ALU
    logic [31:0] alu_in0_0;
    logic [31:0] alu_in0_1;
    logic [31:0] alu_in1_0;
    logic [31:0] alu_in1_1;
    logic [3:0]  alu_ctrl;
    logic        alu_dbl;
    logic [31:0] alu_res_0;
    logic [31:0] alu_res_1;
    // writeback response
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res0;
    logic [31:0] rsp_res1;
    logic        rsp_is_cmp;
    logic        rsp_err;
    // core
    logic        fp_stall;

    modport slave (
        input  req_valid, req_op, req_dbl, req_a0, req_a1, req_b0, req_b1, flush,
        output req_ready,
        output alu_in0_0, alu_in0_1, alu_in1_0, alu_in1_1, alu_ctrl, alu_dbl,
        input  alu_res_0, alu_res_1,
        output rsp_valid, rsp_res0, rsp_res1, rsp_is_cmp, rsp_err,
        input  rsp_ready,
        output fp_stall
    );

    modport master (
        output req_valid, req_op, req_dbl, req_a0, req_a1, req_b0, req_b1, flush,
        input  req_ready,
        input  alu_in0_0, alu_in0_1, alu_in1_0, alu_in1_1, alu_ctrl, alu_dbl,
        output alu_res_0, alu_res_1,
        input  rsp_valid, rsp_res0, rsp_res1, rsp_is_cmp, rsp_err,
        output rsp_ready,
        input  fp_stall
    );
endinterface

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer
//   Multi-cycle issue controller for the shared FP ALU. Accepts one op at a
//   time from decode, holds its operands and control code on the ALU for the
//   op's latency, captures the ALU result and hands it to writeback.
//   Ports:
//     clk    clock
//     rst_n  synchronous active-low reset
//     bus    fp_op_sequencer_if.slave (request, ALU, response, fp_stall)
//   Flow: IDLE -accept-> EXEC (LAT_x cycles) -> RESP -rsp_ready-> IDLE.
//   Illegal requests skip EXEC and answer with rsp_err=1, ALU left at NOP.
module fp_op_sequencer
    import fp_seq_pkg::*;
#(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 8,
    parameter int unsigned LAT_CMP = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_op_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      in0_0_reg, in0_0_next;
    logic [31:0]      in0_1_reg, in0_1_next;
    logic [31:0]      in1_0_reg, in1_0_next;
    logic [31:0]      in1_1_reg, in1_1_next;
    logic [3:0]       ctrl_reg, ctrl_next;
    logic             dbl_reg, dbl_next;
    logic [31:0]      res0_reg, res0_next;
    logic [31:0]      res1_reg, res1_next;
    logic             is_cmp_reg, is_cmp_next;
    logic             err_reg, err_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            in0_0_reg  <= '0;
            in0_1_reg  <= '0;
            in1_0_reg  <= '0;
            in1_1_reg  <= '0;
            ctrl_reg   <= ALU_CTRL_NOP;
            dbl_reg    <= 1'b0;
            res0_reg   <= '0;
            res1_reg   <= '0;
            is_cmp_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            in0_0_reg  <= in0_0_next;
            in0_1_reg  <= in0_1_next;
            in1_0_reg  <= in1_0_next;
            in1_1_reg  <= in1_1_next;
            ctrl_reg   <= ctrl_next;
            dbl_reg    <= dbl_next;
            res0_reg   <= res0_next;
            res1_reg   <= res1_next;
            is_cmp_reg <= is_cmp_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        in0_0_next  = in0_0_reg;
        in0_1_next  = in0_1_reg;
        in1_0_next  = in1_0_reg;
        in1_1_next  = in1_1_reg;
        ctrl_next   = ctrl_reg;
        dbl_next    = dbl_reg;
        res0_next   = res0_reg;
        res1_next   = res1_reg;
        is_cmp_next = is_cmp_reg;
        err_next    = err_reg;

        case (state_reg)
            S_IDLE: begin
                // flush in the same cycle as a request wins: nothing accepted.
                if (bus.req_valid && !bus.flush) begin
                    res0_next = '0;
                    res1_next = '0;
                    if (is_legal(bus.req_op, bus.req_dbl)) begin
                        in0_0_next  = bus.req_a0;
                        in0_1_next  = bus.req_a1;
                        in1_0_next  = bus.req_b0;
                        in1_1_next  = bus.req_b1;
                        ctrl_next   = ctrl_of(bus.req_op);
                        dbl_next    = bus.req_dbl;
                        cnt_next    = CNT_W'(lat_of(bus.req_op, LAT_ADD, LAT_MUL,
                                                    LAT_DIV, LAT_CMP));
                        is_cmp_next = is_cmp_op(bus.req_op);
                        err_next    = 1'b0;
                        state_next  = S_EXEC;
                    end else begin
                        ctrl_next   = ALU_CTRL_NOP;
                        dbl_next    = 1'b0;
                        is_cmp_next = 1'b0;
                        err_next    = 1'b1;
                        state_next  = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (bus.flush) begin
                    ctrl_next  = ALU_CTRL_NOP;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                    // Last held cycle: the ALU output is final, grab it and
                    // release the ALU on the same edge.
                    if (cnt_reg == CNT_ONE) begin
                        res0_next  = is_cmp_reg ? '0 : bus.alu_res_0;
                        res1_next  = (dbl_reg && !is_cmp_reg) ? bus.alu_res_1 : '0;
                        ctrl_next  = ALU_CTRL_NOP;
                        state_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.flush || bus.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                ctrl_next  = ALU_CTRL_NOP;
            end
        endcase
    end

    assign bus.req_ready  = (state_reg == S_IDLE);
    assign bus.fp_stall   = (state_reg != S_IDLE);
    assign bus.rsp_valid  = (state_reg == S_RESP);
    assign bus.alu_in0_0  = in0_0_reg;
    assign bus.alu_in0_1  = in0_1_reg;
    assign bus.alu_in1_0  = in1_0_reg;
    assign bus.alu_in1_1  = in1_1_reg;
    assign bus.alu_ctrl   = ctrl_reg;
    assign bus.alu_dbl    = dbl_reg;
    assign bus.rsp_res0   = res0_reg;
    assign bus.rsp_res1   = res1_reg;
    assign bus.rsp_is_cmp = is_cmp_reg;
    assign bus.rsp_err    = err_reg;

endmodule
